uart_pixel_rx: RTL and testbench

UART_PIXEL_RX -- requirements
Module: uart_pixel_rx

---
 rtl/uart_pixel_rx.sv | 139 +++++++++++++
 tb/tb_uart_pixel_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_pixel_rx.sv
// 8N1 serial receiver that turns pixel bytes into frame-buffer writes.
// Bytes with bit7 set rewind the write pointer to the top of the frame.
module uart_pixel_rx #(
  parameter int CLOCK_RATE = 1000,
  parameter int BAUD_RATE  = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_data,
  output logic       wr_en,
  output logic [5:0] wr_addr,
  output logic [2:0] wr_data,
  output logic       frame_done,
  output logic       framing_error,
  output logic       busy
);

  localparam int CPB = CLOCK_RATE / BAUD_RATE;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CPB / 2 - 1);

  if (CPB < 4) begin : g_bad_cpb
    $error("uart_pixel_rx: CLOCK_RATE/BAUD_RATE must be >= 4");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } state_t;

  state_t          r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [2:0]      r_bit, w_bit_n;
  logic [7:0]      r_shift, w_shift_n;
  logic            r_sync1, r_rx_s;
  logic [5:0]      r_ptr;
  logic            w_accept, w_ferr;
  logic            w_unused;

  assign w_unused = ^r_shift[6:3];
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= uart_data;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + 1'b1;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_accept  = 1'b0;
    w_ferr    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
        if (!r_rx_s) w_state_n = S_START;
      end
      S_START: begin
        if (r_cnt == C_HALF) begin
          w_cnt_n   = '0;
          w_bit_n   = '0;
          w_state_n = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == C_LAST) begin
          w_cnt_n          = '0;
          w_shift_n[r_bit] = r_rx_s;
          w_bit_n          = r_bit + 1'b1;
          if (r_bit == 3'd7) w_state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == C_LAST) begin
          w_cnt_n   = '0;
          w_accept  = r_rx_s;
          w_ferr    = !r_rx_s;
          w_state_n = r_rx_s ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        w_cnt_n = '0;
        if (r_rx_s) w_state_n = S_IDLE;
      end
      default: begin
        w_cnt_n   = '0;
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr         <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      frame_done    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      wr_en         <= 1'b0;
      frame_done    <= 1'b0;
      framing_error <= w_ferr;
      if (w_accept) begin
        if (r_shift[7]) begin
          r_ptr <= '0;
        end else begin
          wr_en      <= 1'b1;
          wr_addr    <= r_ptr;
          wr_data    <= r_shift[2:0];
          frame_done <= (r_ptr == 6'd63);
          r_ptr      <= r_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_pixel_rx.sv
// Scoreboard bench for uart_pixel_rx: a byte-level model predicts writes,
// a monitor compares every strobe the DUT presents.
module tb_uart_pixel_rx;

  localparam int CPB = 10;

  typedef struct {
    int addr;
    int data;
    int fd;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       uart_data = 1'b1;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [2:0] wr_data;
  logic       frame_done;
  logic       framing_error;
  logic       busy;

  int  n_checks = 0;
  int  n_err = 0;
  int  m_ptr = 0;
  int  exp_ferr = 0;
  int  ferr_seen = 0;
  int  last_addr = 0;
  int  last_data = 0;
  wr_t exp_q[$];

  uart_pixel_rx #(.CLOCK_RATE(1000), .BAUD_RATE(100)) dut (
    .clk(clk),
    .reset(reset),
    .uart_data(uart_data),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_done(frame_done),
    .framing_error(framing_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: what one received byte should do to the panel.
  task automatic model_byte(input logic [7:0] b, input logic ok);
    wr_t w;
    if (!ok) begin
      exp_ferr++;
    end else if (b[7]) begin
      m_ptr = 0;
    end else begin
      w.addr = m_ptr;
      w.data = int'(b[2:0]);
      w.fd   = (m_ptr == 63) ? 1 : 0;
      exp_q.push_back(w);
      m_ptr = (m_ptr + 1) % 64;
    end
  endtask

  task automatic drive_bit(input logic v);
    uart_data = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ok);
    model_byte(b, ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(ok);
  endtask

  task automatic idle(input int n);
    uart_data = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_wr_data"}, int'(wr_data), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_ferr"}, int'(framing_error), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  always @(negedge clk) begin
    wr_t w;
    if (!reset) begin
      last_addr = 0;
      last_data = 0;
    end else if (wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", int'(wr_addr), -1);
      end else begin
        w = exp_q.pop_front();
        chk("wr_addr", int'(wr_addr), w.addr);
        chk("wr_data", int'(wr_data), w.data);
        chk("frame_done", int'(frame_done), w.fd);
      end
      last_addr = int'(wr_addr);
      last_data = int'(wr_data);
    end else begin
      if (frame_done) chk("frame_done_alone", 1, 0);
      if (int'(wr_addr) != last_addr) chk("addr_hold", int'(wr_addr), last_addr);
      if (int'(wr_data) != last_data) chk("data_hold", int'(wr_data), last_data);
    end
    if (reset && framing_error) ferr_seen++;
  end

  initial begin
    logic [7:0] b;
    logic       ok;
    int         gap;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    idle(5);

    send_byte(8'h05, 1'b1);
    idle(CPB);
    chk("q_after_05", exp_q.size(), 0);

    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h80, 1'b1);
    send_byte(8'h07, 1'b1);
    idle(CPB);
    chk("q_after_seq", exp_q.size(), 0);

    send_byte(8'h80, 1'b1);
    for (int i = 0; i < 64; i++) send_byte(8'(i), 1'b1);
    send_byte(8'h3A, 1'b1);
    idle(CPB);
    chk("q_after_frame", exp_q.size(), 0);

    uart_data = 1'b0;
    repeat (3) @(negedge clk);
    idle(2 * CPB);
    chk("glitch_busy", int'(busy), 0);
    chk("glitch_ferr_cnt", ferr_seen, exp_ferr);

    send_byte(8'h80, 1'b1);
    send_byte(8'h04, 1'b0);
    repeat (25) @(negedge clk);
    chk("break_busy", int'(busy), 1);
    repeat (25) @(negedge clk);
    chk("break_busy_end", int'(busy), 1);
    idle(CPB);
    chk("break_exit_busy", int'(busy), 0);
    chk("ferr_cnt", ferr_seen, exp_ferr);
    send_byte(8'h06, 1'b1);
    idle(CPB);
    chk("q_after_break", exp_q.size(), 0);

    b = 8'h55;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    uart_data = b[4];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_zero("midreset");
    m_ptr = 0;
    uart_data = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle(CPB);
    send_byte(8'h02, 1'b1);
    idle(CPB);
    chk("q_after_midreset", exp_q.size(), 0);

    for (int i = 0; i < 40; i++) begin
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 9) != 0);
      gap = $urandom_range(0, 15);
      send_byte(b, ok);
      if (!ok) gap = gap + CPB;
      idle(gap);
    end
    idle(2 * CPB);
    chk("q_after_random", exp_q.size(), 0);
    chk("ferr_total", ferr_seen, exp_ferr);
    chk("final_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
